// File: rtl/capture_readback.sv
// Streams a captured record out of the capture BRAM over a valid/ready byte link.
// Optional running checksum of delivered bytes is enabled with READBACK_CHECKSUM_EN.
module capture_readback #(
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   num_samples,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_din,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   rd_count,
  output logic [7:0]        checksum
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned WAIT_W = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT    = 3'd2,
    PRESENT = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  remaining;
  logic [WAIT_W-1:0] wait_cnt;
  logic              accept, take, capture;

  assign bram_we = 1'b0;

  // Next-state and per-cycle strobes; abort overrides everything outside IDLE.
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    take    = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          accept  = 1'b1;
          state_d = (num_samples == '0) ? FINISH : FETCH;
        end
      end
      FETCH:   state_d = WAIT;
      WAIT: begin
        if (wait_cnt == WAIT_W'(RD_LATENCY - 1)) begin
          capture = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (m_valid && m_ready) begin
          take    = 1'b1;
          state_d = (remaining == CNT_W'(1)) ? FINISH : FETCH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state != IDLE) begin
      state_d = IDLE;
      take    = 1'b0;
      capture = 1'b0;
    end
  end

  // State register and registered outputs; bram_addr doubles as the read pointer.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      remaining <= '0;
      wait_cnt  <= '0;
      bram_en   <= 1'b0;
      bram_addr <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_count  <= '0;
    end else begin
      state    <= state_d;
      bram_en  <= (state_d == FETCH);
      m_valid  <= (state_d == PRESENT);
      busy     <= (state_d != IDLE);
      wait_cnt <= (state == WAIT && state_d == WAIT) ? wait_cnt + WAIT_W'(1) : '0;
      if (capture) m_data <= bram_din;
      if (accept) begin
        bram_addr <= start_addr;
        remaining <= num_samples;
        rd_count  <= '0;
      end else if (take) begin
        bram_addr <= bram_addr + ADDR_W'(1);
        remaining <= remaining - CNT_W'(1);
        rd_count  <= rd_count + CNT_W'(1);
      end
      // A zero-length run enters FINISH on the accepting edge, so set wins over clear.
      if (state_d == FINISH) done <= 1'b1;
      else if (accept)       done <= 1'b0;
    end
  end

`ifdef READBACK_CHECKSUM_EN
  // Modulo-256 sum of the low byte of every delivered sample in this run.
  always_ff @(posedge clk) begin
    if (!resetn)     checksum <= '0;
    else if (accept) checksum <= '0;
    else if (take)   checksum <= checksum + 8'(m_data);
  end
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_capture_readback.sv
// Directed bench for capture_readback with a 1-cycle synchronous BRAM model.
module tb_capture_readback;

  localparam int unsigned ADDR_W     = 18;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned RD_LATENCY = 1;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W:0]   num_samples = '0;
  logic              bram_en, bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din = '0;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic              busy, done;
  logic [ADDR_W:0]   rd_count;
  logic [7:0]        checksum;

  int vectors = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [7:0]        got_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  int                en_count = 0;
  int                valid_cycles = 0;

  capture_readback #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .start_addr(start_addr), .num_samples(num_samples),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .rd_count(rd_count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bram_en) bram_din <= mem[bram_addr];

  // Inputs only change just after posedge, so negedge sees what the next edge will act on.
  always @(negedge clk) begin
    if (resetn && m_valid && m_ready) got_q.push_back(m_data);
    if (resetn && bram_en) begin
      addr_q.push_back(bram_addr);
      en_count++;
    end
    if (m_valid) valid_cycles++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    addr_q.delete();
    en_count = 0;
    valid_cycles = 0;
  endtask

  task automatic start_run(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] n);
    start_addr  = a;
    num_samples = n;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_timeout_idle: busy=%b after %0d cycles, expected 0", name, busy, budget);
    end
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    while (m_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (m_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_timeout_valid: m_valid=%b after %0d cycles, expected 1", name, m_valid, budget);
    end
  endtask

  function automatic logic [63:0] got_packed();
    logic [63:0] p = '0;
    foreach (got_q[i]) p = {p[55:0], got_q[i]};
    return p;
  endfunction

  function automatic logic [71:0] addr_packed();
    logic [71:0] p = '0;
    foreach (addr_q[i]) p = {p[53:0], addr_q[i]};
    return p;
  endfunction

  function automatic logic [7:0] exp_csum(input logic [7:0] s);
    logic [7:0] mask;
`ifdef READBACK_CHECKSUM_EN
    mask = 8'hFF;
`else
    mask = 8'h00;
`endif
    return s & mask;
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    vectors++;
    if ({bram_en, bram_we, bram_addr, m_data, m_valid, busy, done, rd_count, checksum} !== 58'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: en=%b we=%b addr=%h data=%h valid=%b busy=%b done=%b cnt=%0d csum=%h, expected all 0",
               bram_en, bram_we, bram_addr, m_data, m_valid, busy, done, rd_count, checksum);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    clear_mon();
    m_ready = 1'b1;
    start_run(18'h0, 19'd4);
    vectors++;
    if (m_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_cycle1: m_valid=%b busy=%b, expected 0/1", m_valid, busy);
    end
    tick();
    vectors++;
    if (m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_cycle2: m_valid=%b, expected 0", m_valid);
    end
    tick();
    vectors++;
    if (m_valid !== 1'b1 || m_data !== 8'h11) begin
      miscompares++;
      $display("FAIL basic_first_valid: m_valid=%b m_data=%h, expected 1/11", m_valid, m_data);
    end
    wait_idle(40, "basic");
    vectors++;
    if (got_q.size() != 4 || got_packed() !== 64'h11223344) begin
      miscompares++;
      $display("FAIL basic_stream: got %h (n=%0d), expected 11223344 (n=4)", got_packed(), got_q.size());
    end
    vectors++;
    if (done !== 1'b1 || rd_count !== 19'd4 || en_count != 4) begin
      miscompares++;
      $display("FAIL basic_status: done=%b rd_count=%0d fetches=%0d, expected 1/4/4", done, rd_count, en_count);
    end
    vectors++;
    if (checksum !== exp_csum(8'hAA)) begin
      miscompares++;
      $display("FAIL basic_checksum: got %h, expected %h", checksum, exp_csum(8'hAA));
    end
  endtask

  task automatic test_wrap();
    clear_mon();
    m_ready = 1'b1;
    start_run(18'h3FFFE, 19'd4);
    wait_idle(40, "wrap");
    vectors++;
    if (addr_q.size() != 4 || addr_packed() !== {18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001}) begin
      miscompares++;
      $display("FAIL wrap_addr: got %h (n=%0d), expected %h", addr_packed(), addr_q.size(),
               {18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001});
    end
    vectors++;
    if (got_q.size() != 4 || got_packed() !== 64'hA1A21122 || rd_count !== 19'd4) begin
      miscompares++;
      $display("FAIL wrap_stream: got %h (n=%0d) rd_count=%0d, expected a1a21122 (n=4) 4",
               got_packed(), got_q.size(), rd_count);
    end
    vectors++;
    if (checksum !== exp_csum(8'h76)) begin
      miscompares++;
      $display("FAIL wrap_checksum: got %h, expected %h", checksum, exp_csum(8'h76));
    end
  endtask

  task automatic test_backpressure();
    logic stable;
    clear_mon();
    m_ready = 1'b0;
    start_run(18'h0, 19'd2);
    wait_valid(10, "bp");
    stable = 1'b1;
    repeat (5) begin
      tick();
      if (m_valid !== 1'b1 || m_data !== 8'h11) stable = 1'b0;
    end
    vectors++;
    if (stable !== 1'b1 || en_count != 1) begin
      miscompares++;
      $display("FAIL bp_hold: stable=%b fetches=%0d m_data=%h, expected 1/1/11", stable, en_count, m_data);
    end
    m_ready = 1'b1;
    wait_idle(40, "bp");
    vectors++;
    if (got_q.size() != 2 || got_packed() !== 64'h1122 || rd_count !== 19'd2) begin
      miscompares++;
      $display("FAIL bp_stream: got %h (n=%0d) rd_count=%0d, expected 1122 (n=2) 2",
               got_packed(), got_q.size(), rd_count);
    end
    vectors++;
    if (checksum !== exp_csum(8'h33)) begin
      miscompares++;
      $display("FAIL bp_checksum: got %h, expected %h", checksum, exp_csum(8'h33));
    end
  endtask

  task automatic test_zero();
    clear_mon();
    m_ready = 1'b1;
    start_run(18'h5, 19'd0);
    vectors++;
    if (done !== 1'b1 || rd_count !== 19'd0) begin
      miscompares++;
      $display("FAIL zero_done: done=%b rd_count=%0d, expected 1/0", done, rd_count);
    end
    tick();
    tick();
    tick();
    vectors++;
    if (busy !== 1'b0 || en_count != 0 || valid_cycles != 0 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_quiet: busy=%b fetches=%0d valid_cycles=%0d done=%b, expected 0/0/0/1",
               busy, en_count, valid_cycles, done);
    end
  endtask

  task automatic test_abort();
    int n;
    clear_mon();
    m_ready = 1'b1;
    start_run(18'h100, 19'd10);
    n = 0;
    while (got_q.size() < 2 && n < 100) begin
      tick();
      n++;
    end
    wait_valid(10, "abort");
    vectors++;
    if (m_data !== 8'h52) begin
      miscompares++;
      $display("FAIL abort_third: m_data=%h, expected 52", m_data);
    end
    m_ready = 1'b0;
    abort   = 1'b1;
    tick();
    abort   = 1'b0;
    vectors++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bram_en !== 1'b0 || rd_count !== 19'd2) begin
      miscompares++;
      $display("FAIL abort_state: valid=%b busy=%b done=%b en=%b rd_count=%0d, expected 0/0/0/0/2",
               m_valid, busy, done, bram_en, rd_count);
    end
    tick();
    tick();
    vectors++;
    if (en_count != 3 || checksum !== exp_csum(8'hA1) || rd_count !== 19'd2) begin
      miscompares++;
      $display("FAIL abort_hold: fetches=%0d csum=%h rd_count=%0d, expected 3/%h/2",
               en_count, checksum, rd_count, exp_csum(8'hA1));
    end
    abort = 1'b1;
    start_run(18'h100, 19'd3);
    abort = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0 || en_count != 3) begin
      miscompares++;
      $display("FAIL abort_over_start: busy=%b fetches=%0d, expected 0/3", busy, en_count);
    end
    clear_mon();
    m_ready = 1'b1;
    start_run(18'h100, 19'd3);
    wait_idle(40, "abort_rerun");
    vectors++;
    if (got_q.size() != 3 || got_packed() !== 64'h505152 || done !== 1'b1 || rd_count !== 19'd3) begin
      miscompares++;
      $display("FAIL abort_rerun: got %h (n=%0d) done=%b rd_count=%0d, expected 505152 (n=3) 1 3",
               got_packed(), got_q.size(), done, rd_count);
    end
    vectors++;
    if (checksum !== exp_csum(8'hF3)) begin
      miscompares++;
      $display("FAIL abort_rerun_checksum: got %h, expected %h", checksum, exp_csum(8'hF3));
    end
  endtask

  task automatic test_reset_mid();
    int e;
    clear_mon();
    m_ready = 1'b0;
    start_run(18'h0, 19'd4);
    wait_valid(10, "rstmid");
    resetn = 1'b0;
    tick();
    vectors++;
    if ({bram_en, bram_addr, m_data, m_valid, busy, done, rd_count, checksum} !== 57'd0) begin
      miscompares++;
      $display("FAIL rstmid_outputs: en=%b addr=%h data=%h valid=%b busy=%b done=%b cnt=%0d csum=%h, expected all 0",
               bram_en, bram_addr, m_data, m_valid, busy, done, rd_count, checksum);
    end
    resetn = 1'b1;
    e = en_count;
    repeat (4) tick();
    vectors++;
    if (en_count != e || m_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_quiet: fetches=%0d->%0d valid=%b busy=%b, expected no change/0/0",
               e, en_count, m_valid, busy);
    end
    m_ready = 1'b1;
  endtask

  task automatic test_start_busy();
    clear_mon();
    m_ready = 1'b1;
    start_run(18'h200, 19'd4);
    tick();
    tick();
    start_run(18'h0, 19'd1);
    wait_idle(60, "busy_start");
    vectors++;
    if (got_q.size() != 4 || got_packed() !== 64'hC0C1C2C3 || rd_count !== 19'd4 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_start_stream: got %h (n=%0d) rd_count=%0d done=%b, expected c0c1c2c3 (n=4) 4 1",
               got_packed(), got_q.size(), rd_count, done);
    end
    vectors++;
    if (addr_q.size() != 4 || addr_packed() !== {18'h200, 18'h201, 18'h202, 18'h203}) begin
      miscompares++;
      $display("FAIL busy_start_addr: got %h (n=%0d), expected %h", addr_packed(), addr_q.size(),
               {18'h200, 18'h201, 18'h202, 18'h203});
    end
    vectors++;
    if (checksum !== exp_csum(8'h06)) begin
      miscompares++;
      $display("FAIL busy_start_checksum: got %h, expected %h", checksum, exp_csum(8'h06));
    end
  endtask

  initial begin
    mem[18'h00000] = 8'h11;
    mem[18'h00001] = 8'h22;
    mem[18'h00002] = 8'h33;
    mem[18'h00003] = 8'h44;
    mem[18'h3FFFE] = 8'hA1;
    mem[18'h3FFFF] = 8'hA2;
    for (int i = 0; i < 10; i++) mem[18'h100 + i] = 8'h50 + 8'(i);
    for (int i = 0; i < 4; i++)  mem[18'h200 + i] = 8'hC0 + 8'(i);

    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero();
    test_abort();
    test_reset_mid();
    test_start_busy();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
